eth_frame_loop_writer: RTL and testbench

- Upstream feeder of the frame detector's 512-deep loop FIFO.
- Takes the non-stallable byte stream from the RX MAC and packs each byte into the FIFO's 9-bit beat: bit 8 is the bad-frame flag, valid only on tlast beats.
- Drops whole frames when the FIFO is near full at start of frame.
- Cuts frames cleanly when backpressure hits mid-frame, and keeps written/dropped/truncated counters for the stats block.

---
 rtl/eth_frame_loop_writer_pkg.sv | 21 ++
 rtl/eth_frame_loop_writer_if.sv | 28 ++
 rtl/eth_frame_loop_writer.sv | 132 +++++++++++++
 tb/tb_eth_frame_loop_writer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_frame_loop_writer_pkg.sv
// Shared types and beat layout for the loop-FIFO writer.
// Beat bit 8 is the bad-frame flag and only carries meaning on tlast beats.
package eth_frame_loop_pkg;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    PASS,
    DROP
  } state_t;

  localparam int LOOP_BEAT_W  = 9;
  localparam int LOOP_BAD_BIT = 8;

  function automatic logic [LOOP_BEAT_W-1:0] pack_beat(input logic [7:0] data,
                                                       input logic       user,
                                                       input logic       last);
    pack_beat = {last & user, data};
  endfunction

endpackage

// File: rtl/eth_frame_loop_writer_if.sv
// Stream boundary of the loop writer: RX MAC byte stream in, loop FIFO beats out.
// The writer connects through the slave modport; its environment uses master.
interface eth_frame_loop_writer_if;
  import eth_frame_loop_pkg::*;

  logic [7:0]             s_axis_tdata;
  logic                   s_axis_tuser;
  logic                   s_axis_tlast;
  logic                   s_axis_tvalid;
  logic                   fifo_prog_full;
  logic [LOOP_BEAT_W-1:0] m_axis_tdata;
  logic                   m_axis_tlast;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;

  modport master (
    output s_axis_tdata, s_axis_tuser, s_axis_tlast, s_axis_tvalid,
    output fifo_prog_full, m_axis_tready,
    input  m_axis_tdata, m_axis_tlast, m_axis_tvalid
  );

  modport slave (
    input  s_axis_tdata, s_axis_tuser, s_axis_tlast, s_axis_tvalid,
    input  fifo_prog_full, m_axis_tready,
    output m_axis_tdata, m_axis_tlast, m_axis_tvalid
  );

endinterface

// File: rtl/eth_frame_loop_writer.sv
// Packs the non-stallable RX byte stream into loop FIFO beats, dropping or
// cutting frames cleanly under backpressure and counting each outcome.
//
// state | meaning
// SYNC  | after reset; discard until a tlast beat so no fragment is emitted
// IDLE  | between frames; next valid beat is a first byte
// PASS  | mid-frame, beats are being written
// DROP  | discarding the rest of a dropped or cut frame
module eth_frame_loop_writer
  import eth_frame_loop_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  eth_frame_loop_writer_if.slave bus,
  output logic [CNT_WIDTH-1:0] cnt_written,
  output logic [CNT_WIDTH-1:0] cnt_dropped,
  output logic [CNT_WIDTH-1:0] cnt_truncated
);

  state_t                 state_q, state_d;
  logic                   tvalid_q, tvalid_d;
  logic [LOOP_BEAT_W-1:0] tdata_q, tdata_d;
  logic                   tlast_q, tlast_d;
  logic [CNT_WIDTH-1:0]   written_q, written_d;
  logic [CNT_WIDTH-1:0]   dropped_q, dropped_d;
  logic [CNT_WIDTH-1:0]   truncated_q, truncated_d;

  logic free;
  logic in_beat;
  logic in_last;
  logic inc_written, inc_dropped, inc_truncated;

  assign free    = !tvalid_q || bus.m_axis_tready;
  assign in_beat = bus.s_axis_tvalid;
  assign in_last = bus.s_axis_tvalid && bus.s_axis_tlast;

  always_comb begin
    state_d       = state_q;
    tvalid_d      = tvalid_q && !bus.m_axis_tready;
    tdata_d       = tdata_q;
    tlast_d       = tlast_q;
    inc_written   = 1'b0;
    inc_dropped   = 1'b0;
    inc_truncated = 1'b0;

    case (state_q)
      SYNC: begin
        if (in_last) state_d = IDLE;
      end

      IDLE: begin
        if (in_beat) begin
          if (bus.fifo_prog_full || !free) begin
            inc_dropped = 1'b1;
            state_d     = bus.s_axis_tlast ? IDLE : DROP;
          end else begin
            tvalid_d = 1'b1;
            tdata_d  = pack_beat(bus.s_axis_tdata, bus.s_axis_tuser, bus.s_axis_tlast);
            tlast_d  = bus.s_axis_tlast;
            if (bus.s_axis_tlast) begin
              inc_written   = !bus.s_axis_tuser;
              inc_truncated = bus.s_axis_tuser;
            end else begin
              state_d = PASS;
            end
          end
        end
      end

      PASS: begin
        if (in_beat) begin
          if (free) begin
            tvalid_d = 1'b1;
            tdata_d  = pack_beat(bus.s_axis_tdata, bus.s_axis_tuser, bus.s_axis_tlast);
            tlast_d  = bus.s_axis_tlast;
            if (bus.s_axis_tlast) begin
              inc_written   = !bus.s_axis_tuser;
              inc_truncated = bus.s_axis_tuser;
              state_d       = IDLE;
            end
          end else begin
            // Held beat is never tlast here, so closing it in place is safe.
            tlast_d                = 1'b1;
            tdata_d[LOOP_BAD_BIT]  = 1'b1;
            inc_truncated          = 1'b1;
            state_d                = bus.s_axis_tlast ? IDLE : DROP;
          end
        end
      end

      DROP: begin
        if (in_last) state_d = IDLE;
      end

      default: state_d = SYNC;
    endcase

    written_d   = written_q   + CNT_WIDTH'(inc_written);
    dropped_d   = dropped_q   + CNT_WIDTH'(inc_dropped);
    truncated_d = truncated_q + CNT_WIDTH'(inc_truncated);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SYNC;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      written_q   <= '0;
      dropped_q   <= '0;
      truncated_q <= '0;
    end else begin
      state_q     <= state_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      written_q   <= written_d;
      dropped_q   <= dropped_d;
      truncated_q <= truncated_d;
    end
  end

  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign cnt_written       = written_q;
  assign cnt_dropped       = dropped_q;
  assign cnt_truncated     = truncated_q;

endmodule

// File: tb/tb_eth_frame_loop_writer.sv
// Directed bench for eth_frame_loop_writer: a per-cycle vector table for the
// FSM corner cases, then frame-level sequences checked against an expected beat queue.
module tb_eth_frame_loop_writer;

  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_frame_loop_writer_if bus();
  logic [CW-1:0] cnt_written, cnt_dropped, cnt_truncated;

  eth_frame_loop_writer #(.CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .cnt_written  (cnt_written),
    .cnt_dropped  (cnt_dropped),
    .cnt_truncated(cnt_truncated)
  );

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       u;
    logic       l;
    logic       pf;
    logic       rdy;
    logic       etv;
    logic [8:0] etd;
    logic       etl;
  } vec_t;

  vec_t tbl [0:22];

  int errors = 0;
  int checks = 0;

  // {tlast, tdata[8:0]} of every beat the FIFO accepts
  logic [9:0] beats_q[$];
  logic [9:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n && bus.m_axis_tvalid && bus.m_axis_tready)
      beats_q.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic u,
                       input logic l, input logic pf, input logic rdy);
    bus.s_axis_tvalid  = v;
    bus.s_axis_tdata   = d;
    bus.s_axis_tuser   = u;
    bus.s_axis_tlast   = l;
    bus.fifo_prog_full = pf;
    bus.m_axis_tready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.s_axis_tvalid  = 1'b0;
    bus.s_axis_tdata   = 8'h00;
    bus.s_axis_tuser   = 1'b0;
    bus.s_axis_tlast   = 1'b0;
    bus.fifo_prog_full = 1'b0;
    bus.m_axis_tready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input int n, input int base, input logic user);
    for (int k = 0; k < n; k++)
      drive(1'b1, 8'(base + k), user && (k == n - 1), k == n - 1, 1'b0, 1'b1);
  endtask

  task automatic expect_frame(input int n, input int base, input logic user);
    for (int k = 0; k < n; k++)
      exp_q.push_back({k == n - 1, user && (k == n - 1), 8'(base + k)});
  endtask

  task automatic cmp_beats(input string nm);
    int n;
    chk({nm, "_beat_count"}, 32'(beats_q.size()), 32'(exp_q.size()));
    n = (beats_q.size() < exp_q.size()) ? beats_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_beat%0d", nm, i), 32'(beats_q[i]), 32'(exp_q[i]));
    beats_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // v, d, u, l, pf, rdy | expected tvalid, tdata, tlast after the edge
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0};
    tbl[1]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0};
    tbl[2]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b1};
    tbl[3]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 9'h15A, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h15A, 1'b1};
    tbl[5]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h15A, 1'b1};
    tbl[6]  = '{1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0};
    tbl[7]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0};
    tbl[8]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0};
    tbl[9]  = '{1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h040, 1'b0};
    tbl[10] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 9'h041, 1'b0};
    tbl[11] = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h141, 1'b1};
    tbl[12] = '{1'b1, 8'h43, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h141, 1'b1};
    tbl[13] = '{1'b1, 8'h50, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h050, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h050, 1'b0};
    tbl[15] = '{1'b1, 8'h51, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 9'h051, 1'b1};
    tbl[16] = '{1'b1, 8'h60, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h051, 1'b1};
    tbl[17] = '{1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h051, 1'b1};
    tbl[18] = '{1'b1, 8'h62, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0};
    tbl[19] = '{1'b1, 8'h70, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h070, 1'b0};
    tbl[20] = '{1'b1, 8'h71, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h170, 1'b1};
    tbl[21] = '{1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 9'h080, 1'b1};
    tbl[22] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0};

    do_reset();
    chk("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(bus.m_axis_tdata), 32'd0);
    chk("rst_tlast", 32'(bus.m_axis_tlast), 32'd0);
    chk("rst_written", cnt_written, 32'd0);
    chk("rst_dropped", cnt_dropped, 32'd0);
    chk("rst_truncated", cnt_truncated, 32'd0);

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].u, tbl[i].l, tbl[i].pf, tbl[i].rdy);
      chk($sformatf("vec%0d_tvalid", i), 32'(bus.m_axis_tvalid), 32'(tbl[i].etv));
      if (tbl[i].etv) begin
        chk($sformatf("vec%0d_tdata", i), 32'(bus.m_axis_tdata), 32'(tbl[i].etd));
        chk($sformatf("vec%0d_tlast", i), 32'(bus.m_axis_tlast), 32'(tbl[i].etl));
      end
    end
    chk("tbl_written", cnt_written, 32'd3);
    chk("tbl_dropped", cnt_dropped, 32'd4);
    chk("tbl_truncated", cnt_truncated, 32'd3);

    // 64-byte frame, one-cycle latency on every beat
    do_reset();
    drive(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 64; k++) begin
      drive(1'b1, 8'(k), 1'b0, k == 63, 1'b0, 1'b1);
      chk($sformatf("f64_tvalid%0d", k), 32'(bus.m_axis_tvalid), 32'd1);
      chk($sformatf("f64_tdata%0d", k), 32'(bus.m_axis_tdata), 32'(k));
      chk($sformatf("f64_tlast%0d", k), 32'(bus.m_axis_tlast), 32'(k == 63));
    end
    idle(2);
    chk("f64_written", cnt_written, 32'd1);
    beats_q.delete();

    // MAC error on the last byte
    expect_frame(5, 8'h80, 1'b1);
    send_frame(5, 8'h80, 1'b1);
    idle(2);
    cmp_beats("tuser");
    chk("tuser_truncated", cnt_truncated, 32'd1);
    chk("tuser_written", cnt_written, 32'd1);

    // near-full on the first byte only drops the whole frame
    for (int k = 0; k < 20; k++)
      drive(1'b1, 8'(k), 1'b0, k == 19, k == 0, 1'b1);
    idle(2);
    cmp_beats("pfull");
    chk("pfull_dropped", cnt_dropped, 32'd1);
    expect_frame(10, 8'h20, 1'b0);
    send_frame(10, 8'h20, 1'b0);
    idle(2);
    cmp_beats("after_pfull");
    chk("after_pfull_written", cnt_written, 32'd2);

    // backpressure mid-frame cuts it at byte 9
    for (int k = 0; k < 30; k++)
      drive(1'b1, 8'(k), 1'b0, k == 29, 1'b0, !(k >= 10 && k < 13));
    idle(3);
    for (int k = 0; k < 9; k++) exp_q.push_back({1'b0, 1'b0, 8'(k)});
    exp_q.push_back(10'h309);
    cmp_beats("cut");
    chk("cut_truncated", cnt_truncated, 32'd2);
    chk("cut_dropped", cnt_dropped, 32'd1);
    expect_frame(4, 8'h30, 1'b0);
    send_frame(4, 8'h30, 1'b0);
    idle(2);
    cmp_beats("after_cut");
    chk("after_cut_written", cnt_written, 32'd3);

    // reset in the middle of a frame leaves no fragment behind
    for (int k = 0; k < 30; k++) begin
      if (k == 15) rst_n = 1'b0;
      if (k == 20) rst_n = 1'b1;
      drive(1'b1, 8'(k), 1'b0, k == 29, 1'b0, 1'b1);
    end
    beats_q.delete();
    idle(2);
    chk("rstmid_no_beats", 32'(beats_q.size()), 32'd0);
    chk("rstmid_written", cnt_written, 32'd0);
    expect_frame(6, 8'h50, 1'b0);
    send_frame(6, 8'h50, 1'b0);
    idle(2);
    cmp_beats("after_rstmid");
    chk("after_rstmid_written", cnt_written, 32'd1);

    // back-to-back single-byte frames
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({1'b1, 1'b0, 8'(8'hC0 + i)});
      drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b1, 1'b0, 1'b1);
      chk($sformatf("b2b_tvalid%0d", i), 32'(bus.m_axis_tvalid), 32'd1);
    end
    idle(2);
    cmp_beats("b2b");
    chk("b2b_written", cnt_written, 32'd9);
    chk("b2b_dropped", cnt_dropped, 32'd0);
    chk("b2b_truncated", cnt_truncated, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
